// File: rtl/xorshift_checker.sv
// Receive-side xorshift sequence checker: hunts for a seed, verifies, then tracks the
// stream and flags every word that departs from the regenerated sequence.
module xorshift_checker #(
   parameter int WIDTH        = 32,
   parameter int SHIFT_A      = 13,
   parameter int SHIFT_B      = 17,
   parameter int SHIFT_C      = 5,
   parameter int LOCK_COUNT   = 4,
   parameter int UNLOCK_COUNT = 3,
   parameter int COUNT_WIDTH  = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   input  logic [WIDTH-1:0]       in_data,
   input  logic                   resync,
   input  logic                   clear_count,
   output logic                   locked,
   output logic                   error,
   output logic [COUNT_WIDTH-1:0] error_count
);

   localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
   localparam int MISS_W  = $clog2(UNLOCK_COUNT + 1);

   typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

   state_t                 state_q, state_d;
   logic [WIDTH-1:0]       expected_q, expected_d;
   logic [MATCH_W-1:0]     match_cnt_q, match_cnt_d;
   logic [MISS_W-1:0]      miss_cnt_q, miss_cnt_d;
   logic                   locked_q, locked_d;
   logic                   error_q, error_d;
   logic [COUNT_WIDTH-1:0] error_count_q, error_count_d;

   logic [WIDTH-1:0]       next_exp;
   logic [WIDTH-1:0]       next_seed;
   logic [MATCH_W-1:0]     match_inc;
   logic [MISS_W-1:0]      miss_inc;

   function automatic logic [WIDTH-1:0] xs_next(input logic [WIDTH-1:0] x);
      logic [WIDTH-1:0] t;
      t = x ^ (x << SHIFT_A);
      t = t ^ (t >> SHIFT_B);
      t = t ^ (t << SHIFT_C);
      return t;
   endfunction

   always_comb begin
      state_d       = state_q;
      expected_d    = expected_q;
      match_cnt_d   = match_cnt_q;
      miss_cnt_d    = miss_cnt_q;
      error_count_d = error_count_q;
      error_d       = 1'b0;
      next_exp      = xs_next(expected_q);
      next_seed     = xs_next(in_data);
      match_inc     = match_cnt_q + 1'b1;
      miss_inc      = miss_cnt_q + 1'b1;

      if (resync) begin
         state_d     = HUNT;
         expected_d  = '0;
         match_cnt_d = '0;
         miss_cnt_d  = '0;
      end else if (in_valid) begin
         unique case (state_q)
            HUNT: begin
               // Zero never occurs in the sequence, so it cannot serve as a seed.
               if (in_data != '0) begin
                  expected_d  = next_seed;
                  match_cnt_d = '0;
                  state_d     = VERIFY;
               end
            end
            VERIFY: begin
               if (in_data == expected_q) begin
                  expected_d  = next_exp;
                  match_cnt_d = match_inc;
                  if (match_inc == MATCH_W'(LOCK_COUNT)) begin
                     state_d = LOCKED;
                  end
               end else if (in_data != '0) begin
                  expected_d  = next_seed;
                  match_cnt_d = '0;
               end else begin
                  match_cnt_d = '0;
                  state_d     = HUNT;
               end
            end
            LOCKED: begin
               // Once locked the expectation free-runs so one bad word costs one error.
               expected_d = next_exp;
               if (in_data == expected_q) begin
                  miss_cnt_d = '0;
               end else begin
                  error_d    = 1'b1;
                  miss_cnt_d = miss_inc;
                  if (error_count_q != '1) begin
                     error_count_d = error_count_q + 1'b1;
                  end
                  if (miss_inc == MISS_W'(UNLOCK_COUNT)) begin
                     miss_cnt_d  = '0;
                     match_cnt_d = '0;
                     state_d     = HUNT;
                  end
               end
            end
            default: state_d = HUNT;
         endcase
      end

      if (clear_count) begin
         error_count_d = '0;
      end
      locked_d = (state_d == LOCKED);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= HUNT;
         expected_q    <= '0;
         match_cnt_q   <= '0;
         miss_cnt_q    <= '0;
         locked_q      <= 1'b0;
         error_q       <= 1'b0;
         error_count_q <= '0;
      end else begin
         state_q       <= state_d;
         expected_q    <= expected_d;
         match_cnt_q   <= match_cnt_d;
         miss_cnt_q    <= miss_cnt_d;
         locked_q      <= locked_d;
         error_q       <= error_d;
         error_count_q <= error_count_d;
      end
   end

   assign locked      = locked_q;
   assign error       = error_q;
   assign error_count = error_count_q;

endmodule

// File: tb/tb_xorshift_checker.sv
// Randomised self-checking bench for xorshift_checker: two instances (default and a
// small saturating counter variant) run against a protocol-level reference model.
module tb_xorshift_checker;

   logic        clock;
   logic        resetN;
   logic        inValid;
   logic [31:0] inData;
   logic        resync;
   logic        clearCount;
   logic        locked0, error0;
   logic [15:0] errorCount0;
   logic        locked1, error1;
   logic [1:0]  errorCount1;

   int compared;
   int mismatched;

   // Reference model state, index 0 = default instance, 1 = saturating variant.
   // mState: 0 hunting, 1 verifying, 2 locked.
   int          mState[2];
   logic [31:0] mExp[2];
   int          mRun[2];
   int          mMiss[2];
   int          mCount[2];
   int          mLocked[2];
   int          mError[2];
   int          unlockLim[2] = '{3, 8};
   int          countMax[2]  = '{65535, 3};

   logic [31:0] genState;

   xorshift_checker dut (
      .clk(clock), .reset(resetN), .in_valid(inValid), .in_data(inData),
      .resync(resync), .clear_count(clearCount),
      .locked(locked0), .error(error0), .error_count(errorCount0)
   );

   xorshift_checker #(.COUNT_WIDTH(2), .UNLOCK_COUNT(8)) dutSat (
      .clk(clock), .reset(resetN), .in_valid(inValid), .in_data(inData),
      .resync(resync), .clear_count(clearCount),
      .locked(locked1), .error(error1), .error_count(errorCount1)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Sequence successor computed with plain modular arithmetic instead of shifts.
   function automatic logic [31:0] refNext(input logic [31:0] w);
      longint unsigned x;
      longint unsigned m;
      m = 64'd4294967296;
      x = {32'd0, w};
      x = x ^ ((x * 64'd8192) % m);
      x = x ^ (x / 64'd131072);
      x = x ^ ((x * 64'd32) % m);
      return x[31:0];
   endfunction

   task automatic checkOutput(input string tag, input longint obs, input longint exp);
      compared++;
      if (obs != exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic modelReset();
      for (int k = 0; k < 2; k++) begin
         mState[k] = 0; mExp[k] = '0; mRun[k] = 0; mMiss[k] = 0;
         mCount[k] = 0; mLocked[k] = 0; mError[k] = 0;
      end
   endtask

   task automatic modelStep(input logic v, input logic [31:0] w, input logic rs, input logic clr);
      for (int k = 0; k < 2; k++) begin
         mError[k] = 0;
         if (rs) begin
            mState[k] = 0; mRun[k] = 0; mMiss[k] = 0;
         end else if (v) begin
            if (mState[k] == 0) begin
               if (w != 0) begin
                  mExp[k] = refNext(w); mRun[k] = 0; mState[k] = 1;
               end
            end else if (mState[k] == 1) begin
               if (w == mExp[k]) begin
                  mExp[k] = refNext(mExp[k]);
                  mRun[k]++;
                  if (mRun[k] == 4) mState[k] = 2;
               end else if (w != 0) begin
                  mExp[k] = refNext(w); mRun[k] = 0;
               end else begin
                  mState[k] = 0;
               end
            end else begin
               if (w != mExp[k]) begin
                  mError[k] = 1;
                  if (mCount[k] < countMax[k]) mCount[k]++;
                  mMiss[k]++;
                  if (mMiss[k] == unlockLim[k]) begin
                     mState[k] = 0; mMiss[k] = 0;
                  end
               end else begin
                  mMiss[k] = 0;
               end
               mExp[k] = refNext(mExp[k]);
            end
         end
         if (clr) mCount[k] = 0;
         mLocked[k] = (mState[k] == 2) ? 1 : 0;
      end
   endtask

   task automatic checkAll();
      checkOutput("locked0", locked0, mLocked[0]);
      checkOutput("error0", error0, mError[0]);
      checkOutput("count0", errorCount0, mCount[0]);
      checkOutput("locked1", locked1, mLocked[1]);
      checkOutput("error1", error1, mError[1]);
      checkOutput("count1", errorCount1, mCount[1]);
   endtask

   // Called at a falling edge: drive, clock, update model, check just after the edge.
   task automatic applyStimulus(input logic v, input logic [31:0] w, input logic rs, input logic clr);
      inValid = v; inData = w; resync = rs; clearCount = clr;
      @(posedge clock);
      modelStep(v, w, rs, clr);
      #1;
      checkAll();
      @(negedge clock);
   endtask

   task automatic sendGood();
      applyStimulus(1'b1, genState, 1'b0, 1'b0);
      genState = refNext(genState);
   endtask

   task automatic sendBad(input logic clr);
      applyStimulus(1'b1, genState ^ ($urandom | 32'd1), 1'b0, clr);
      genState = refNext(genState);
   endtask

   task automatic lockUp(input string tag, input bit withGaps, output int n);
      n = 0;
      for (int i = 0; i < 12 && !locked0; i++) begin
         if (withGaps) begin
            int gaps;
            gaps = $urandom_range(0, 3);
            for (int g = 0; g < gaps; g++) applyStimulus(1'b0, $urandom, 1'b0, 1'b0);
         end
         sendGood();
         n++;
      end
      checkOutput(tag, locked0, 1);
   endtask

   initial begin
      int n;
      compared = 0;
      mismatched = 0;
      resetN = 1'b0; inValid = 1'b0; inData = '0; resync = 1'b0; clearCount = 1'b0;
      modelReset();
      repeat (2) @(negedge clock);
      checkAll();
      resetN = 1'b1;

      // Plain generator stream from seed 1 locks after exactly five valid words.
      genState = 32'h0000_0001;
      lockUp("lockPlain", 1'b0, n);
      checkOutput("lockLatency", n, 5);
      repeat (3) sendGood();

      // Same stream with idle gaps must lock identically.
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      lockUp("lockGaps", 1'b1, n);
      checkOutput("gapLatency", n, 5);

      // Single corrupted word: one error, lock kept, stream continues to match.
      sendBad(1'b0);
      checkOutput("oneErrCount", errorCount0, 1);
      checkOutput("oneErrLocked", locked0, 1);
      repeat (3) sendGood();

      // Three consecutive bad words drop lock on the default instance only.
      repeat (3) sendBad(1'b0);
      checkOutput("unlockAfter3", locked0, 0);
      checkOutput("threeErrCount", errorCount0, 4);
      lockUp("relock", 1'b0, n);
      checkOutput("relockWithin5", (n <= 5) ? 1 : 0, 1);

      // Garbage after lock saturates the 2-bit counter; clear wins over an increment.
      repeat (6) sendBad(1'b0);
      checkOutput("satCount", errorCount1, 3);
      checkOutput("satLocked", locked1, 1);
      sendBad(1'b1);
      checkOutput("clearCount", errorCount1, 0);
      checkOutput("clearErrPulse", error1, 1);
      lockUp("relockAfterGarbage", 1'b0, n);

      // Resync while locked keeps the error count.
      repeat (2) sendBad(1'b0);
      sendGood();
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      checkOutput("resyncUnlock", locked0, 0);
      checkOutput("resyncKeep", errorCount0, 2);

      // Leading zero words are ignored while hunting; then seed from a random word.
      repeat (3) applyStimulus(1'b1, '0, 1'b0, 1'b0);
      genState = $urandom | 32'd1;
      lockUp("lockRandomSeed", 1'b0, n);
      checkOutput("zeroSkipLatency", n, 5);

      // Randomised mix of good, bad and idle words with occasional resync/clear.
      for (int i = 0; i < 300; i++) begin
         int r;
         r = $urandom_range(0, 99);
         if (r < 60) sendGood();
         else if (r < 72) sendBad(1'b0);
         else if (r < 90) applyStimulus(1'b0, $urandom, 1'b0, 1'b0);
         else if (r < 93) applyStimulus(1'b1, '0, 1'b0, 1'b0);
         else if (r < 96) sendBad(1'b1);
         else if (r < 98) applyStimulus(1'b1, genState, 1'b1, 1'b0);
         else begin
            applyStimulus(1'b1, $urandom, 1'b0, 1'b0);
            genState = refNext(genState);
         end
      end

      // Asynchronous reset asserted mid-cycle while locked clears outputs at once.
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      lockUp("lockBeforeReset", 1'b0, n);
      sendBad(1'b0);
      #2;
      resetN = 1'b0;
      #1;
      modelReset();
      checkAll();
      @(negedge clock);
      resetN = 1'b1;
      applyStimulus(1'b1, '0, 1'b0, 1'b0);
      lockUp("lockAfterReset", 1'b0, n);
      checkOutput("resetLatency", n, 5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
